// File: rtl/cpu_defs.sv
// Constants shared by the PC, F/D register and CP0 blocks: CP0 exception codes and the
// architectural reset and handler addresses.
package cpu_defs;

   typedef logic [4:0] exccode_t;

   // EXC_NONE shares the encoding of Int because an interrupt never travels down the pipe
   // as a per-instruction code; CP0 raises it directly.
   localparam exccode_t EXC_NONE = 5'd0;
   localparam exccode_t EXC_MOD  = 5'd1;
   localparam exccode_t EXC_TLBL = 5'd2;
   localparam exccode_t EXC_TLBS = 5'd3;
   localparam exccode_t EXC_ADEL = 5'd4;
   localparam exccode_t EXC_ADES = 5'd5;
   localparam exccode_t EXC_IBE  = 5'd6;
   localparam exccode_t EXC_DBE  = 5'd7;
   localparam exccode_t EXC_SYS  = 5'd8;
   localparam exccode_t EXC_BP   = 5'd9;
   localparam exccode_t EXC_RI   = 5'd10;
   localparam exccode_t EXC_CPU  = 5'd11;
   localparam exccode_t EXC_OV   = 5'd12;

   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

endpackage

// File: rtl/fetch_decode_reg_if.sv
// F-side inputs and D-side outputs of the F/D pipeline register.
interface fetch_decode_reg_if;
   import cpu_defs::exccode_t;

   logic        req;
   logic        stall;
   logic [31:0] instr_f;
   logic [31:0] pc_f;
   logic        adel_f;
   logic        bd_f;

   logic [31:0] instr_d;
   logic [31:0] pc_d;
   exccode_t    exccode_d;
   logic        bd_d;
   logic        valid_d;

   modport master (
      output req, stall, instr_f, pc_f, adel_f, bd_f,
      input  instr_d, pc_d, exccode_d, bd_d, valid_d
   );

   modport slave (
      input  req, stall, instr_f, pc_f, adel_f, bd_f,
      output instr_d, pc_d, exccode_d, bd_d, valid_d
   );
endinterface

// File: rtl/fetch_decode_reg_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/fetch_decode_reg.sv
// F/D pipeline register: one-cycle F-to-D latch with flush, stall and address-error
// squashing, plus saturating fetch/stall/flush cycle counters.
module fetch_decode_reg #(
   parameter logic [31:0] RESET_PC   = cpu_defs::RESET_PC,
   parameter logic [31:0] HANDLER_PC = cpu_defs::HANDLER_PC,
   parameter int          CNT_W      = 32
) (
   input  logic               clk,
   input  logic               reset,
   fetch_decode_reg_if.slave  fd,
   output logic [CNT_W-1:0]   cnt_fetch,
   output logic [CNT_W-1:0]   cnt_stall,
   output logic [CNT_W-1:0]   cnt_flush
);
   import cpu_defs::EXC_NONE;
   import cpu_defs::EXC_ADEL;

   logic flush;
   logic hold;
   logic load;

   // Case-equality so an unknown req never flushes, matching the PC stage.
   assign flush = (fd.req === 1'b1);
   assign hold  = !flush && fd.stall;
   assign load  = !flush && !fd.stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         fd.instr_d   <= 32'h0;
         fd.pc_d      <= RESET_PC;
         fd.exccode_d <= EXC_NONE;
         fd.bd_d      <= 1'b0;
         fd.valid_d   <= 1'b0;
      end else if (flush) begin
         fd.instr_d   <= 32'h0;
         fd.pc_d      <= HANDLER_PC;
         fd.exccode_d <= EXC_NONE;
         fd.bd_d      <= 1'b0;
         fd.valid_d   <= 1'b0;
      end else if (load) begin
         fd.pc_d    <= fd.pc_f;
         fd.bd_d    <= fd.bd_f;
         fd.valid_d <= 1'b1;
         // A word fetched from a bad address must never reach the decoder.
         if (fd.adel_f) begin
            fd.instr_d   <= 32'h0;
            fd.exccode_d <= EXC_ADEL;
         end else begin
            fd.instr_d   <= fd.instr_f;
            fd.exccode_d <= EXC_NONE;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_cnt_fetch (
      .clk   (clk),
      .reset (reset),
      .inc   (load),
      .count (cnt_fetch)
   );

   sat_counter #(.W(CNT_W)) u_cnt_stall (
      .clk   (clk),
      .reset (reset),
      .inc   (hold),
      .count (cnt_stall)
   );

   sat_counter #(.W(CNT_W)) u_cnt_flush (
      .clk   (clk),
      .reset (reset),
      .inc   (flush),
      .count (cnt_flush)
   );

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Directed bench for fetch_decode_reg built with 4-bit counters so saturation is reachable.
module tb_fetch_decode_reg;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [CNT_W-1:0] cnt_fetch;
   logic [CNT_W-1:0] cnt_stall;
   logic [CNT_W-1:0] cnt_flush;

   int tests = 0;
   int fails = 0;

   fetch_decode_reg_if fd ();

   fetch_decode_reg #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .fd        (fd.slave),
      .cnt_fetch (cnt_fetch),
      .cnt_stall (cnt_stall),
      .cnt_flush (cnt_flush)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_d(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [4:0] exc, input logic bd, input logic valid);
      chk({tag, ".instr_d"},   fd.instr_d,   instr);
      chk({tag, ".pc_d"},      fd.pc_d,      pc);
      chk({tag, ".exccode_d"}, {27'h0, fd.exccode_d}, {27'h0, exc});
      chk({tag, ".bd_d"},      {31'h0, fd.bd_d},      {31'h0, bd});
      chk({tag, ".valid_d"},   {31'h0, fd.valid_d},   {31'h0, valid});
   endtask

   task automatic chk_cnt(input string tag, input int f, input int s, input int fl);
      chk({tag, ".cnt_fetch"}, 32'(cnt_fetch), 32'(f));
      chk({tag, ".cnt_stall"}, 32'(cnt_stall), 32'(s));
      chk({tag, ".cnt_flush"}, 32'(cnt_flush), 32'(fl));
   endtask

   initial begin
      reset      = 1'b1;
      fd.req     = 1'b0;
      fd.stall   = 1'b0;
      fd.instr_f = 32'h0;
      fd.pc_f    = 32'h0;
      fd.adel_f  = 1'b0;
      fd.bd_f    = 1'b0;

      // reset held two cycles
      tick();
      tick();
      chk_d("reset", 32'h0, 32'h3000, 5'd0, 1'b0, 1'b0);
      chk_cnt("reset", 0, 0, 0);

      // first load
      reset      = 1'b0;
      fd.pc_f    = 32'h3000;
      fd.instr_f = 32'h3C01_0001;
      tick();
      chk_d("load1", 32'h3C01_0001, 32'h3000, 5'd0, 1'b0, 1'b1);
      chk_cnt("load1", 1, 0, 0);

      // three stalled cycles while F changes
      fd.stall   = 1'b1;
      fd.instr_f = 32'h0;
      fd.pc_f    = 32'h3004;
      tick();
      tick();
      tick();
      chk_d("stall3", 32'h3C01_0001, 32'h3000, 5'd0, 1'b0, 1'b1);
      chk_cnt("stall3", 1, 3, 0);

      // release stall: new value loads
      fd.stall = 1'b0;
      tick();
      chk_d("unstall", 32'h0, 32'h3004, 5'd0, 1'b0, 1'b1);
      chk_cnt("unstall", 2, 3, 0);

      // fetch address error in a delay slot
      fd.pc_f    = 32'h3002;
      fd.instr_f = 32'h8C00_0000;
      fd.adel_f  = 1'b1;
      fd.bd_f    = 1'b1;
      tick();
      chk_d("adel", 32'h0, 32'h3002, 5'd4, 1'b1, 1'b1);
      chk_cnt("adel", 3, 3, 0);

      // flush overrides stall
      fd.req   = 1'b1;
      fd.stall = 1'b1;
      tick();
      chk_d("flush", 32'h0, 32'h4180, 5'd0, 1'b0, 1'b0);
      chk_cnt("flush", 3, 3, 1);

      // unknown req behaves as no flush
      fd.req     = 1'bx;
      fd.stall   = 1'b0;
      fd.adel_f  = 1'b0;
      fd.bd_f    = 1'b0;
      fd.pc_f    = 32'h3008;
      fd.instr_f = 32'h2442_0001;
      tick();
      chk_d("req_x", 32'h2442_0001, 32'h3008, 5'd0, 1'b0, 1'b1);
      chk_cnt("req_x", 4, 3, 1);

      // long stall drives cnt_stall into saturation (3 + 14 > 15)
      fd.req     = 1'b0;
      fd.stall   = 1'b1;
      fd.instr_f = 32'hFFFF_FFFF;
      fd.pc_f    = 32'h300C;
      for (int i = 0; i < 14; i++) tick();
      chk_d("sat", 32'h2442_0001, 32'h3008, 5'd0, 1'b0, 1'b1);
      chk_cnt("sat", 4, 15, 1);
      tick();
      chk_cnt("sat_hold", 4, 15, 1);

      // reset wins over stall and req on the same edge
      reset  = 1'b1;
      fd.req = 1'b1;
      tick();
      chk_d("reset_mid", 32'h0, 32'h3000, 5'd0, 1'b0, 1'b0);
      chk_cnt("reset_mid", 0, 0, 0);

      // counting resumes from zero after reset
      reset    = 1'b0;
      fd.req   = 1'b0;
      fd.stall = 1'b0;
      fd.pc_f  = 32'h3010;
      fd.instr_f = 32'h0000_0020;
      tick();
      chk_d("post_reset", 32'h0000_0020, 32'h3010, 5'd0, 1'b0, 1'b1);
      chk_cnt("post_reset", 1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fetch_decode_reg.md
Name: fetch_decode_reg

Overview:
- F/D pipeline register of the 5-stage MIPS core with precise exceptions.
- Sits directly downstream of the fetch PC/IM: captures the fetched instruction, its PC, the fetch-address-error flag and the delay-slot flag.
- Presents them to the D stage with a valid bit and an exception code.
- Honours stall and exception/interrupt flush, and keeps saturating performance counters (fetched, stalled, flushed cycles).

Parameters:
- RESET_PC, 32'h0000_3000, pc_d value after reset.
- HANDLER_PC, 32'h0000_4180, pc_d value loaded on flush; keeps the bubble's PC meaningful for the exception logic.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- req  in  1  exception/interrupt being taken this cycle; flush.
- stall  in  1  hazard unit holds D.
- instr_f  in  32  instruction read from IM at pc_f.
- pc_f  in  32  fetch PC (already EPC-overridden on eret).
- adel_f  in  1  fetch address error for pc_f.
- bd_f  in  1  instruction in F is a branch delay slot.
- instr_d  out  32  instruction to decode.
- pc_d  out  32  PC of instr_d.
- exccode_d  out  5  pending exception code carried into D.
- bd_d  out  1  delay-slot flag.
- valid_d  out  1  D holds a real fetched instruction.
- cnt_fetch  out  CNT_W  accepted fetches.
- cnt_stall  out  CNT_W  stalled cycles.
- cnt_flush  out  CNT_W  flush cycles.

Behaviour:
- All state updates on posedge clk only. Latency one cycle, F to D.
- Priority per edge: reset > req > stall > load.
- Reset values:
  - instr_d=0, pc_d=RESET_PC, exccode_d=EXC_NONE, bd_d=0, valid_d=0.
  - All counters 0.
- req=1 (flush):
  - instr_d=0 (nop), pc_d=HANDLER_PC, exccode_d=EXC_NONE, bd_d=0, valid_d=0.
  - Overrides stall, matching PC behaviour of advancing when req is high even while stalled.
- stall=1, req=0: every D output holds its value exactly.
- Load (stall=0, req=0):
  - pc_d=pc_f, bd_d=bd_f, valid_d=1.
  - If adel_f=1: instr_d=0, so the bad-address word never decodes, and exccode_d=EXC_ADEL.
  - Else: instr_d=instr_f, exccode_d=EXC_NONE.
- Counters are updated only when reset=0, per edge:
  - cnt_flush increments when req=1.
  - cnt_stall increments when stall=1 and req=0.
  - cnt_fetch increments on a load.
  - Exactly one counter increments per non-reset cycle.
  - Each counter saturates at all-ones and never wraps.
- Inputs are sampled as-is. X on req is treated as 0 (case-equality compare), consistent with the PC stage. X on stall is not special-cased.
- Reset asserted mid-stall or mid-flush: reset wins on that edge.
- No combinational path from any input to any output.

Decomposition:
- Shared package cpu_defs:
  - EXC_NONE=5'd0, EXC_ADEL=5'd4, plus the remaining CP0 exception codes.
  - RESET_PC and HANDLER_PC constants, reused by the PC and CP0 blocks.
- One sub-module: sat_counter (parameter W; ports clk, reset, inc, count), instantiated three times.

Test Plan:
- Reset for 2 cycles then release → instr_d=0, pc_d=0x3000, valid_d=0, exccode_d=0, all counters 0 during reset.
- Load pc_f=0x3000, instr_f=0x3C010001, adel_f=0, bd_f=0 → next edge: instr_d=0x3C010001, pc_d=0x3000, valid_d=1, cnt_fetch=1.
- stall=1 for 3 cycles while instr_f changes to 0x00000000 → D outputs unchanged, cnt_stall=3. stall=0 → new value loads.
- Load pc_f=0x3002, adel_f=1, bd_f=1 → instr_d=0, exccode_d=4, bd_d=1, pc_d=0x3002, valid_d=1.
- req=1 together with stall=1 → instr_d=0, pc_d=0x4180, valid_d=0, bd_d=0, cnt_flush+1, cnt_stall unchanged.
- Force cnt_stall to all-ones (CNT_W=4 build) and keep stall=1 → stays 4'hF. Then reset mid-stall → all D outputs and counters return to reset values.
